vsync_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vsync_counter.sv | 46 ++++
 rtl/vsync_timing_gen.sv | 100 ++++++++++
 tb/tb_vsync_timing_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg : shared 640x480@60 timing constants and output bundle type
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int c_h_visible    = 640;
  localparam int c_h_sync_start = 656;
  localparam int c_h_sync_end   = 751;
  localparam int c_h_total      = 800;

  localparam int c_v_visible    = 480;
  localparam int c_v_sync_start = 490;
  localparam int c_v_sync_end   = 491;
  localparam int c_v_total      = 525;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
  } sync_out_t;

  localparam sync_out_t c_sync_out_rst = '{
    hsync:       1'b1,
    vsync:       1'b1,
    video_on:    1'b0,
    pixel_x:     10'd0,
    pixel_y:     10'd0,
    frame_start: 1'b0
  };

endpackage

`default_nettype wire

// File: rtl/vsync_counter.sv
// ---------------------------------------------------------------------------
// vsync_counter : vertical line counter with frame counter on wrap
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vsync_counter
  import vga_timing_pkg::*;
#(
  parameter int V_TOTAL = c_v_total
) (
  input  logic        clk_25Hz,
  input  logic        rst_n,
  input  logic        enable,
  output logic [15:0] v_count,
  output logic [7:0]  frame_count
);

  localparam logic [15:0] c_v_last = 16'(V_TOTAL - 1);

  logic [15:0] r_v_count;
  logic [7:0]  r_frame_count;
  logic        w_last_line;

  assign w_last_line = (r_v_count == c_v_last);

  always_ff @(posedge clk_25Hz) begin
    if (!rst_n) begin
      r_v_count     <= '0;
      r_frame_count <= '0;
    end else if (enable) begin
      if (w_last_line) begin
        r_v_count     <= '0;
        r_frame_count <= r_frame_count + 8'd1;
      end else begin
        r_v_count     <= r_v_count + 16'd1;
      end
    end
  end

  assign v_count     = r_v_count;
  assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: rtl/vsync_timing_gen.sv
// ---------------------------------------------------------------------------
// vsync_timing_gen : vertical count plus registered 640x480 sync/blank decode
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vsync_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE    = c_h_visible,
  parameter int H_SYNC_START = c_h_sync_start,
  parameter int H_SYNC_END   = c_h_sync_end,
  parameter int V_VISIBLE    = c_v_visible,
  parameter int V_SYNC_START = c_v_sync_start,
  parameter int V_SYNC_END   = c_v_sync_end,
  parameter int V_TOTAL      = c_v_total
) (
  input  logic        clk_25Hz,
  input  logic        rst_n,
  input  logic        enable_v_counter,
  input  logic [15:0] h_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [15:0] v_count,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam logic [15:0] c_h_vis     = 16'(H_VISIBLE);
  localparam logic [15:0] c_h_sync_lo = 16'(H_SYNC_START);
  localparam logic [15:0] c_h_sync_hi = 16'(H_SYNC_END);
  localparam logic [15:0] c_v_vis     = 16'(V_VISIBLE);
  localparam logic [15:0] c_v_sync_lo = 16'(V_SYNC_START);
  localparam logic [15:0] c_v_sync_hi = 16'(V_SYNC_END);

  logic [15:0] r_h_d;
  logic        r_s1_valid;
  logic [15:0] w_v_count;
  logic        w_video_on;
  sync_out_t   w_next;
  sync_out_t   r_out;

  // r_s1_valid keeps stage 2 at reset values for the first cycle after reset,
  // where r_h_d/v_count still hold reset zeros rather than a real (0,0).
  always_ff @(posedge clk_25Hz) begin
    if (!rst_n) begin
      r_h_d      <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_h_d      <= h_count;
      r_s1_valid <= 1'b1;
    end
  end

  vsync_counter #(
    .V_TOTAL (V_TOTAL)
  ) u_vsync_counter (
    .clk_25Hz    (clk_25Hz),
    .rst_n       (rst_n),
    .enable      (enable_v_counter),
    .v_count     (w_v_count),
    .frame_count (frame_count)
  );

  assign w_video_on = (r_h_d < c_h_vis) && (w_v_count < c_v_vis);

  always_comb begin
    w_next = c_sync_out_rst;
    if (r_s1_valid) begin
      w_next.hsync       = !((r_h_d >= c_h_sync_lo) && (r_h_d <= c_h_sync_hi));
      w_next.vsync       = !((w_v_count >= c_v_sync_lo) && (w_v_count <= c_v_sync_hi));
      w_next.video_on    = w_video_on;
      w_next.pixel_x     = w_video_on ? r_h_d[9:0] : 10'd0;
      w_next.pixel_y     = w_video_on ? w_v_count[9:0] : 10'd0;
      w_next.frame_start = (r_h_d == 16'd0) && (w_v_count == 16'd0);
    end
  end

  always_ff @(posedge clk_25Hz) begin
    if (!rst_n) begin
      r_out <= c_sync_out_rst;
    end else begin
      r_out <= w_next;
    end
  end

  assign hsync       = r_out.hsync;
  assign vsync       = r_out.vsync;
  assign video_on    = r_out.video_on;
  assign pixel_x     = r_out.pixel_x;
  assign pixel_y     = r_out.pixel_y;
  assign frame_start = r_out.frame_start;
  assign v_count     = w_v_count;

endmodule

`default_nettype wire

// File: tb/tb_vsync_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vsync_timing_gen : directed self-checking bench for vsync_timing_gen
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vsync_timing_gen;

  logic        clk_25Hz = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_v_counter = 1'b0;
  logic [15:0] h_count = '0;
  logic        hsync, vsync, video_on, frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic [15:0] v_count;
  logic [7:0]  frame_count;

  // short-frame instance so 256 frame wraps fit in a small cycle count
  logic        rst2_n = 1'b0;
  logic        en2 = 1'b0;
  logic [15:0] h2 = '0;
  logic        hsync2, vsync2, video_on2, frame_start2;
  logic [9:0]  pixel_x2, pixel_y2;
  logic [15:0] v_count2;
  logic [7:0]  frame_count2;

  int tests = 0;
  int errors = 0;
  int hs_low = 0;
  int vs_low = 0;
  int vs_run = 0;
  int vs_max = 0;
  int fs_cnt = 0;
  int hs_fall, hs_rise;

  always #20 clk_25Hz = ~clk_25Hz;

  vsync_timing_gen u_dut (
    .clk_25Hz         (clk_25Hz),
    .rst_n            (rst_n),
    .enable_v_counter (enable_v_counter),
    .h_count          (h_count),
    .hsync            (hsync),
    .vsync            (vsync),
    .video_on         (video_on),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .v_count          (v_count),
    .frame_start      (frame_start),
    .frame_count      (frame_count)
  );

  vsync_timing_gen #(
    .V_VISIBLE    (4),
    .V_SYNC_START (5),
    .V_SYNC_END   (6),
    .V_TOTAL      (8)
  ) u_dut_short (
    .clk_25Hz         (clk_25Hz),
    .rst_n            (rst2_n),
    .enable_v_counter (en2),
    .h_count          (h2),
    .hsync            (hsync2),
    .vsync            (vsync2),
    .video_on         (video_on2),
    .pixel_x          (pixel_x2),
    .pixel_y          (pixel_y2),
    .v_count          (v_count2),
    .frame_start      (frame_start2),
    .frame_count      (frame_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle; afterwards outputs reflect the previous h_count.
  task automatic drive(input logic [15:0] h, input logic en);
    h_count = h;
    enable_v_counter = en;
    @(posedge clk_25Hz);
    #1;
    if (!hsync) hs_low++;
    if (!vsync) begin
      vs_low++;
      vs_run++;
      if (vs_run > vs_max) vs_max = vs_run;
    end else begin
      vs_run = 0;
    end
    if (frame_start) fs_cnt++;
  endtask

  task automatic run_line();
    drive(16'd0, 1'b1);
    for (int i = 1; i < 800; i++) drive(16'(i), 1'b0);
  endtask

  // Out-of-range column with enable: advances a line, stays in blanking.
  task automatic skip_lines(input int n);
    for (int i = 0; i < n; i++) drive(16'd800, 1'b1);
  endtask

  initial begin
    // reset with the horizontal counter running
    rst_n = 1'b0;
    drive(16'd0, 1'b1);
    drive(16'd1, 1'b0);
    drive(16'd2, 1'b0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_video_on", video_on, 0);
    check("rst_v_count", v_count, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_pixel_x", pixel_x, 0);
    rst_n = 1'b1;

    // line step with hsync edge timing
    hs_low = 0;
    hs_fall = -1;
    hs_rise = -1;
    drive(16'd0, 1'b1);
    check("line_v_step", v_count, 1);
    for (int i = 1; i < 800; i++) begin
      drive(16'(i), 1'b0);
      if (!hsync && hs_fall < 0) hs_fall = i;
      if (hs_fall >= 0 && hsync && hs_rise < 0) hs_rise = i;
    end
    check("hsync_fall_at", hs_fall, 657);
    check("hsync_rise_at", hs_rise, 753);
    check("hsync_low_cycles", hs_low, 96);

    // active-area corner
    skip_lines(478);
    check("v_count_479", v_count, 479);
    drive(16'd639, 1'b0);
    drive(16'd640, 1'b0);
    check("corner_video_on", video_on, 1);
    check("corner_pixel_x", pixel_x, 639);
    check("corner_pixel_y", pixel_y, 479);
    check("corner_vsync", vsync, 1);
    drive(16'd641, 1'b0);
    check("blank_video_on", video_on, 0);
    check("blank_pixel_x", pixel_x, 0);
    check("blank_pixel_y", pixel_y, 0);

    // vsync window with real lines around 490/491, then frame wrap
    skip_lines(9);
    vs_low = 0;
    vs_run = 0;
    vs_max = 0;
    for (int l = 0; l < 4; l++) run_line();
    skip_lines(32);
    check("vsync_low_total", vs_low, 1600);
    check("vsync_low_run", vs_max, 1600);
    check("v_count_524", v_count, 524);
    check("frame_count_pre", frame_count, 0);
    fs_cnt = 0;
    drive(16'd0, 1'b1);
    check("wrap_v_count", v_count, 0);
    check("wrap_frame_count", frame_count, 1);
    drive(16'd1, 1'b0);
    check("frame_start_hi", frame_start, 1);
    drive(16'd2, 1'b0);
    check("frame_start_lo", frame_start, 0);
    for (int i = 3; i < 800; i++) drive(16'(i), 1'b0);
    drive(16'd0, 1'b1);
    drive(16'd1, 1'b0);
    check("frame_start_count", fs_cnt, 1);

    // reset mid-frame at line 300, column 400
    skip_lines(299);
    check("v_count_300", v_count, 300);
    drive(16'd400, 1'b0);
    rst_n = 1'b0;
    drive(16'd401, 1'b0);
    check("mid_rst_v_count", v_count, 0);
    check("mid_rst_frame_count", frame_count, 0);
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_video_on", video_on, 0);
    rst_n = 1'b1;
    fs_cnt = 0;
    for (int i = 402; i < 800; i++) drive(16'(i), 1'b0);
    drive(16'd0, 1'b1);
    check("mid_rst_realign", v_count, 1);
    for (int i = 1; i < 800; i++) drive(16'(i), 1'b0);
    skip_lines(523);
    check("mid_rst_no_fs", fs_cnt, 0);
    drive(16'd0, 1'b1);
    drive(16'd1, 1'b0);
    check("mid_rst_fs_after_wrap", frame_start, 1);
    check("mid_rst_frame_count_wrap", frame_count, 1);

    // reset wins over enable
    rst_n = 1'b0;
    drive(16'd0, 1'b1);
    check("rst_over_enable", v_count, 0);
    rst_n = 1'b1;

    // out-of-range column is blanking; enable off leaves v_count alone
    drive(16'd900, 1'b0);
    drive(16'd900, 1'b0);
    check("oor_hsync", hsync, 1);
    check("oor_video_on", video_on, 0);
    check("oor_v_count", v_count, 0);
    drive(16'd900, 1'b1);
    check("oor_enable_v_count", v_count, 1);

    // 256 frame wraps on the short-frame instance
    rst2_n = 1'b0;
    drive(16'd800, 1'b0);
    rst2_n = 1'b1;
    en2 = 1'b1;
    for (int i = 0; i < 8; i++) drive(16'd800, 1'b0);
    check("short_fc_1", frame_count2, 1);
    check("short_v_0", v_count2, 0);
    for (int i = 8; i < 255 * 8; i++) drive(16'd800, 1'b0);
    check("short_fc_255", frame_count2, 255);
    for (int i = 0; i < 8; i++) drive(16'd800, 1'b0);
    check("short_fc_wrap", frame_count2, 0);
    en2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
